// File: rtl/usb_cs_pkg.sv
// Shared constants and FSM state type for the USB command/status decoder.
// Opcodes and status words are visible on the wire and must match the host software.
package usb_cs_pkg;

   localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hBE11;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;

   typedef enum logic [15:0] {
      STATUS_OK      = 16'h0000,
      STATUS_BAD_OP  = 16'h0001,
      STATUS_ZERO_N  = 16'h0002,
      STATUS_TIMEOUT = 16'h0003
   } status_e;

   typedef enum logic [3:0] {
      HUNT,
      GET_CMD,
      SEND_HDR,
      SEND_CMD,
      GET_ADDR,
      GET_DATA,
      REG_RD,
      REG_WAIT,
      SEND_DATA,
      SEND_STATUS
   } state_e;

endpackage

// File: rtl/usb_cs_command_decoder.sv
// Parses command packets from the inbound CS FIFO, drives the local register bus
// and streams the response packet into the outbound CS FIFO.
module usb_cs_command_decoder
   import usb_cs_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_cs_fifo_empty,
   input  logic [15:0] rd_cs_fifo_data,
   output logic        rd_cs_fifo_re,
   input  logic        wr_cs_fifo_full,
   output logic [15:0] wr_cs_fifo_data,
   output logic        wr_cs_fifo_we,
   output logic [15:0] reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [15:0] reg_rdata,
   output logic        busy,
   output logic [15:0] sync_err_count
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state;
   logic          pend;      // a read strobe was issued last cycle; data is valid now
   logic [15:0]   cmd_q;
   logic [15:0]   rdata_q;
   status_e       status_q;
   logic [7:0]    rem_q;
   logic [TW-1:0] tmo_cnt;

   logic fetch_state;
   logic send_state;
   logic tmo_state;
   logic fetch;
   logic push;
   logic timed_out;
   logic last_item;
   logic op_valid;

   assign fetch_state = state inside {HUNT, GET_CMD, GET_ADDR, GET_DATA};
   assign tmo_state   = state inside {GET_ADDR, GET_DATA};
   assign send_state  = state inside {SEND_HDR, SEND_CMD, SEND_DATA, SEND_STATUS};

   // NOTE: the FIFO strobes are combinational because empty/full must gate them in the
   // same cycle; registering them would either drop or duplicate a word.
   assign fetch = !rst && fetch_state && !pend && !rd_cs_fifo_empty;
   assign push  = !rst && send_state && !wr_cs_fifo_full;

   assign rd_cs_fifo_re = fetch;
   assign wr_cs_fifo_we = push;
   assign busy          = (state != HUNT);

   assign timed_out = tmo_state && !pend && rd_cs_fifo_empty && (tmo_cnt == TMO_LAST);
   assign last_item = (rem_q == 8'd1);
   assign op_valid  = (cmd_q[15:8] == OP_WRITE) || (cmd_q[15:8] == OP_READ);

   // NOTE: every branch assigns the output, starting from a default, so no latch is inferred.
   always_comb begin
      wr_cs_fifo_data = 16'h0000;
      case (state)
         SEND_HDR:    wr_cs_fifo_data = SYNC_WORD;
         SEND_CMD:    wr_cs_fifo_data = cmd_q;
         SEND_DATA:   wr_cs_fifo_data = rdata_q;
         SEND_STATUS: wr_cs_fifo_data = status_q;
         default:     wr_cs_fifo_data = 16'h0000;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read below sees
   // the value from before this edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= HUNT;
         pend           <= 1'b0;
         cmd_q          <= 16'h0000;
         rdata_q        <= 16'h0000;
         status_q       <= STATUS_OK;
         rem_q          <= 8'd0;
         tmo_cnt        <= '0;
         reg_addr       <= 16'h0000;
         reg_wdata      <= 16'h0000;
         reg_we         <= 1'b0;
         reg_re         <= 1'b0;
         sync_err_count <= 16'h0000;
      end else begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;
         pend   <= fetch;

         // Only an empty FIFO while waiting for a payload word advances the timeout.
         if (fetch)
            tmo_cnt <= '0;
         else if (tmo_state && !pend && rd_cs_fifo_empty)
            tmo_cnt <= timed_out ? '0 : tmo_cnt + 1'b1;

         case (state)
            HUNT: if (pend) begin
               if (rd_cs_fifo_data == SYNC_WORD)
                  state <= GET_CMD;
               else if (sync_err_count != 16'hFFFF)
                  sync_err_count <= sync_err_count + 16'd1;
            end

            GET_CMD: if (pend) begin
               cmd_q <= rd_cs_fifo_data;
               rem_q <= rd_cs_fifo_data[7:0];
               state <= SEND_HDR;
            end

            SEND_HDR: if (push) state <= SEND_CMD;

            SEND_CMD: if (push) begin
               if (!op_valid) begin
                  status_q <= STATUS_BAD_OP;
                  state    <= SEND_STATUS;
               end else if (rem_q == 8'd0) begin
                  status_q <= STATUS_ZERO_N;
                  state    <= SEND_STATUS;
               end else begin
                  state <= GET_ADDR;
               end
            end

            GET_ADDR: if (pend) begin
               reg_addr <= rd_cs_fifo_data;
               if (cmd_q[15:8] == OP_WRITE) begin
                  state <= GET_DATA;
               end else begin
                  reg_re <= 1'b1;
                  state  <= REG_RD;
               end
            end else if (timed_out) begin
               status_q <= STATUS_TIMEOUT;
               state    <= SEND_STATUS;
            end

            GET_DATA: if (pend) begin
               reg_wdata <= rd_cs_fifo_data;
               reg_we    <= 1'b1;
               rem_q     <= rem_q - 8'd1;
               if (last_item) begin
                  status_q <= STATUS_OK;
                  state    <= SEND_STATUS;
               end else begin
                  state <= GET_ADDR;
               end
            end else if (timed_out) begin
               status_q <= STATUS_TIMEOUT;
               state    <= SEND_STATUS;
            end

            // reg_re is high during REG_RD; the slave answers in the following cycle.
            REG_RD: state <= REG_WAIT;

            REG_WAIT: begin
               rdata_q <= reg_rdata;
               state   <= SEND_DATA;
            end

            SEND_DATA: if (push) begin
               rem_q <= rem_q - 8'd1;
               if (last_item) begin
                  status_q <= STATUS_OK;
                  state    <= SEND_STATUS;
               end else begin
                  state <= GET_ADDR;
               end
            end

            SEND_STATUS: if (push) state <= HUNT;

            default: state <= HUNT;
         endcase
      end
   end

endmodule
